// File: rtl/cfg_loader.sv
// -----------------------------------------------------------------------------
// cfg_loader
//
// Loads the configuration vector of the four-cell fabric from a byte-wide
// frame: sync byte, NBYTES payload bytes (LSB-first), XOR checksum byte.
// The payload is collected in a shadow register. It is copied to config_bit
// in a single cycle, and only after the sync byte, the padding bits and the
// checksum have all been verified. The fabric is held in reset for the whole
// load, so it never runs on a half-written configuration.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   begin a load (IDLE only)
//   abort        in   cancel a load in HEADER/PAYLOAD/CHECK
//   data_in      in   [7:0] frame byte
//   data_valid   in   data_in is valid
//   data_ready   out  loader accepts a byte this cycle
//   config_bit   out  [CFG_WIDTH-1:0] committed configuration
//   fabric_reset out  reset to the fabric cells
//   busy         out  load in progress (any state but IDLE)
//   done         out  one-cycle pulse after a successful commit
//   error        out  last load failed (sticky until next start/reset)
//   err_code     out  [1:0] 01 bad sync, 10 bad checksum, 11 non-zero padding
// -----------------------------------------------------------------------------
module cfg_loader #(
    parameter int          CFG_WIDTH = 124,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [CFG_WIDTH-1:0] config_bit,
    output logic                 fabric_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);

    localparam int NBYTES = (CFG_WIDTH + 7) / 8;
    localparam int PAD    = 8 * NBYTES - CFG_WIDTH;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
    // Bits of the last payload byte that lie above CFG_WIDTH.
    localparam logic [7:0]       PAD_MASK = ~(8'hFF >> PAD);

    localparam logic [1:0] ERR_SYNC  = 2'b01;
    localparam logic [1:0] ERR_CKSUM = 2'b10;
    localparam logic [1:0] ERR_PAD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [CFG_WIDTH-1:0] shadow;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           cksum;

    logic                 take;        // byte consumed this edge
    logic                 load_clear;  // load accepted: clear frame context
    logic                 fail;
    logic [1:0]           fail_code;

    function automatic logic pad_bad(input logic [7:0] b);
        return |(b & PAD_MASK);
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and handshake
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        data_ready = 1'b0;
        load_clear = 1'b0;
        fail       = 1'b0;
        fail_code  = 2'b00;

        case (state)
            S_IDLE: begin
                // start wins over a simultaneous abort here
                if (start) begin
                    state_next = S_HEADER;
                    load_clear = 1'b1;
                end
            end

            S_HEADER: begin
                data_ready = 1'b1;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (data_valid) begin
                    if (data_in == SYNC_BYTE) begin
                        state_next = S_PAYLOAD;
                    end else begin
                        state_next = S_IDLE;
                        fail       = 1'b1;
                        fail_code  = ERR_SYNC;
                    end
                end
            end

            S_PAYLOAD: begin
                data_ready = 1'b1;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (data_valid && (cnt == LAST_IDX)) begin
                    if (pad_bad(data_in)) begin
                        state_next = S_IDLE;
                        fail       = 1'b1;
                        fail_code  = ERR_PAD;
                    end else begin
                        state_next = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                data_ready = 1'b1;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (data_valid) begin
                    if (data_in == cksum) begin
                        state_next = S_COMMIT;
                    end else begin
                        state_next = S_IDLE;
                        fail       = 1'b1;
                        fail_code  = ERR_CKSUM;
                    end
                end
            end

            S_COMMIT: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Abort has priority: the byte presented alongside it is not consumed.
    assign take = data_valid && data_ready && !abort;
    assign busy = (state != S_IDLE);

    // -------------------------------------------------------------------------
    // Status and committed configuration
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            config_bit   <= '0;
            fabric_reset <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            // Fabric is held in reset exactly while the loader is away from IDLE.
            fabric_reset <= (state_next != S_IDLE);
            done         <= (state == S_COMMIT);

            if (state == S_COMMIT) begin
                config_bit <= shadow;
            end

            if (load_clear) begin
                error    <= 1'b0;
                err_code <= 2'b00;
            end else if (fail) begin
                error    <= 1'b1;
                err_code <= fail_code;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame collection: shadow register, byte counter, running checksum
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (load_clear) begin
            shadow <= '0;
            cnt    <= '0;
            cksum  <= 8'h00;
        end else if ((state == S_PAYLOAD) && take) begin
            // Byte k lands on bits [8k+7:8k]; bits past CFG_WIDTH are dropped.
            for (int i = 0; i < CFG_WIDTH; i++) begin
                if ((i / 8) == int'(cnt)) begin
                    shadow[i] <= data_in[3'(i % 8)];
                end
            end
            cnt   <= cnt + 1'b1;
            cksum <= cksum ^ data_in;
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_loader
//
// Directed frames (good, gapped, bad sync, bad checksum, bad padding, abort,
// reset mid-load, back-to-back) against cfg_loader. A frame-level model keeps
// the bytes of the current load in a queue and decides the outcome from the
// queue length and contents; its expectations are compared with every DUT
// output on every cycle, and literal values pin the key results.
// -----------------------------------------------------------------------------
module tb_cfg_loader;

    localparam int         CFG_WIDTH = 124;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam int         NBYTES    = 16;
    localparam int         PAD       = 4;

    localparam logic [CFG_WIDTH-1:0] GOOD_CFG = 124'h0C0F0E0D0C0B0A090807060504030201;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic [7:0]           data_in;
    logic                 data_valid;
    logic                 data_ready;
    logic [CFG_WIDTH-1:0] config_bit;
    logic                 fabric_reset;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [1:0]           err_code;

    cfg_loader #(
        .CFG_WIDTH (CFG_WIDTH),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .config_bit   (config_bit),
        .fabric_reset (fabric_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // ---------------- frame-level model ----------------
    bit                   armed = 1'b0;
    bit                   m_active;   // collecting frame bytes
    bit                   m_pend;     // frame verified, commit next edge
    logic [7:0]           q[$];       // bytes accepted in this load
    logic [CFG_WIDTH-1:0] m_cfg;
    bit                   m_fr;
    bit                   m_done;
    bit                   m_err;
    logic [1:0]           m_code;
    int                   start_cyc = 0;
    int                   done_cyc  = 0;
    int                   done_cnt  = 0;

    logic [7:0]           frame[$];   // stimulus bytes

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] payload_xor();
        logic [7:0] x = 8'h00;
        for (int k = 1; k <= NBYTES; k++) x = x ^ q[k];
        return x;
    endfunction

    function automatic logic [CFG_WIDTH-1:0] pack_payload();
        logic [CFG_WIDTH-1:0] r = '0;
        for (int k = 0; k < NBYTES; k++)
            for (int b = 0; b < 8; b++)
                if (8 * k + b < CFG_WIDTH) r[8 * k + b] = q[k + 1][b];
        return r;
    endfunction

    task automatic model_fail(input logic [1:0] c);
        m_active = 1'b0;
        m_err    = 1'b1;
        m_code   = c;
        m_fr     = 1'b0;
    endtask

    task automatic model_step();
        int n;
        if (reset) begin
            armed    = 1'b1;
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_cfg    = '0;
            m_fr     = 1'b1;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_code   = 2'b00;
        end else begin
            m_done = 1'b0;
            if (m_pend) begin
                m_cfg  = pack_payload();
                m_done = 1'b1;
                m_pend = 1'b0;
                m_fr   = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active  = 1'b1;
                    q.delete();
                    m_err     = 1'b0;
                    m_code    = 2'b00;
                    m_fr      = 1'b1;
                    start_cyc = cyc;
                end else begin
                    m_fr = 1'b0;
                end
            end else if (abort) begin
                m_active = 1'b0;
                m_fr     = 1'b0;
            end else if (data_valid) begin
                q.push_back(data_in);
                n = q.size();
                if (n == 1 && q[0] != SYNC) begin
                    model_fail(2'b01);
                end else if (n == NBYTES + 1 && (q[n-1] >> (8 - PAD)) != 8'h00) begin
                    model_fail(2'b11);
                end else if (n == NBYTES + 2) begin
                    if (q[n-1] == payload_xor()) begin
                        m_active = 1'b0;
                        m_pend   = 1'b1;
                    end else begin
                        model_fail(2'b10);
                    end
                end
            end
        end
    endtask

    // Single compare process: model advances on the edge, outputs checked 1 later.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            if (armed) begin
                check("cfg",          config_bit,   m_cfg);
                check("fabric_reset", fabric_reset, m_fr);
                check("busy",         busy,         m_active || m_pend);
                check("data_ready",   data_ready,   m_active);
                check("done",         done,         m_done);
                check("error",        error,        m_err);
                check("err_code",     err_code,     m_code);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic a, input logic v, input logic [7:0] d);
        @(negedge clk);
        start      = s;
        abort      = a;
        data_valid = v;
        data_in    = d;
    endtask

    task automatic build_frame(input logic [7:0] last, input logic [7:0] cks);
        frame.delete();
        frame.push_back(SYNC);
        for (int i = 1; i <= 15; i++) frame.push_back(8'(i));
        frame.push_back(last);
        frame.push_back(cks);
    endtask

    // Present the first n frame bytes; each one leaves when data_ready is seen.
    task automatic send_bytes(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            forever begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    drive(1'b0, 1'b0, 1'b0, 8'($urandom));
                end else begin
                    drive(1'b0, 1'b0, 1'b1, frame[i]);
                    if (data_ready) break;
                end
                guard++;
                if (guard > 50) begin
                    fails++;
                    tests++;
                    $display("FAIL byte_timeout: byte %0d not accepted, data_ready=%0b required 1", i, data_ready);
                    break;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;

        // ---- reset with random inputs ----
        repeat (3) begin
            @(negedge clk);
            start      = 1'($urandom_range(0, 1));
            abort      = 1'($urandom_range(0, 1));
            data_valid = 1'($urandom_range(0, 1));
            data_in    = 8'($urandom);
        end
        @(negedge clk);
        check("rst_cfg",   config_bit,   '0);
        check("rst_fr",    fabric_reset, 1'b1);
        check("rst_busy",  busy,         1'b0);
        check("rst_done",  done,         1'b0);
        check("rst_error", error,        1'b0);
        check("rst_code",  err_code,     2'b00);
        check("rst_ready", data_ready,   1'b0);
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        check("rel_fr", fabric_reset, 1'b0);

        // ---- good frame, data_valid continuous ----
        build_frame(8'h0C, 8'h0C);
        done_cnt = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(NBYTES + 2, 1'b0);
        idle(3);
        check("good_cfg",       config_bit,           GOOD_CFG);
        check("good_model_cfg", m_cfg,                GOOD_CFG);
        check("good_latency",   done_cyc - start_cyc, 19);
        check("good_done_cnt",  done_cnt,             1);
        check("good_fr",        fabric_reset,         1'b0);

        // ---- same frame with random valid gaps ----
        done_cnt = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(NBYTES + 2, 1'b1);
        idle(3);
        check("gap_cfg",      config_bit, GOOD_CFG);
        check("gap_done_cnt", done_cnt,   1);
        check("gap_error",    error,      1'b0);

        // ---- bad sync ----
        frame.delete();
        frame.push_back(8'h5A);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(1, 1'b0);
        idle(1);
        check("sync_error", error,      1'b1);
        check("sync_code",  err_code,   2'b01);
        check("sync_ready", data_ready, 1'b0);
        check("sync_cfg",   config_bit, GOOD_CFG);

        // ---- bad checksum ----
        build_frame(8'h0A, 8'h0C);
        done_cnt = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(NBYTES + 2, 1'b0);
        idle(3);
        check("cks_error", error,      1'b1);
        check("cks_code",  err_code,   2'b10);
        check("cks_cfg",   config_bit, GOOD_CFG);
        check("cks_done",  done_cnt,   0);

        // ---- non-zero padding: checksum byte must not be accepted ----
        build_frame(8'h1C, 8'h1C);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(NBYTES + 1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h1C);
        check("pad_ready", data_ready, 1'b0);
        check("pad_error", error,      1'b1);
        check("pad_code",  err_code,   2'b11);
        idle(2);
        check("pad_cfg",   config_bit, GOOD_CFG);

        // ---- abort together with payload byte 7 ----
        build_frame(8'h0C, 8'h0C);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(7, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h07);
        idle(1);
        check("abort_busy",  busy,         1'b0);
        check("abort_error", error,        1'b0);
        check("abort_code",  err_code,     2'b00);
        check("abort_fr",    fabric_reset, 1'b0);
        check("abort_cfg",   config_bit,   GOOD_CFG);

        // ---- reset while waiting for the checksum byte ----
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(NBYTES + 1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("chk_busy",  busy,       1'b1);
        check("chk_ready", data_ready, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_cfg",   config_bit,   '0);
        check("mid_rst_fr",    fabric_reset, 1'b1);
        check("mid_rst_busy",  busy,         1'b0);
        check("mid_rst_ready", data_ready,   1'b0);
        reset = 1'b0;

        // ---- two good frames back to back ----
        done_cnt = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(NBYTES + 2, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("b2b_done_now", done,       1'b1);
        check("b2b_cfg1",     config_bit, GOOD_CFG);
        send_bytes(NBYTES + 2, 1'b0);
        idle(3);
        check("b2b_cfg2",     config_bit, GOOD_CFG);
        check("b2b_done_cnt", done_cnt,   2);
        check("b2b_error",    error,      1'b0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
